if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 94 +++++++++
 tb/tb_if_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives the instruction-memory request and feeds the IF/ID register,
// with stall hold, branch/jump redirect and discard of a stale outstanding response.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcWrite,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] ifidPCin,
  output logic [31:0] ifidInstructionIn,
  output logic        ifidWrite,
  output logic        ifFlush
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] PC_RST = RESET_PC & 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_fetch;
  logic        w_held;
  logic        w_drain;

  assign w_redirect = branchTaken | jump;
  assign w_target   = (branchTaken ? branchTarget : jumpTarget) & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_pc + 32'd4;

  assign w_fetch = (r_state == FETCH);
  assign w_held  = (r_state == HOLD);
  assign w_drain = (r_state == DRAIN);

  // Outputs are qualified by rst so they drop the instant reset asserts.
  assign imemReq           = rst & w_fetch;
  assign imemAddr          = r_pc;
  assign ifidPCin          = w_pc_plus4;
  assign ifidInstructionIn = w_held ? r_hold : imemData;
  assign ifidWrite         = rst & ~w_redirect & pcWrite & ((w_fetch & imemValid) | w_held);
  assign ifFlush           = rst & (w_redirect | (pcWrite & ((w_fetch & ~imemValid) | w_drain)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FETCH;
      r_pc    <= PC_RST;
      r_hold  <= '0;
    end else if (w_redirect) begin
      r_pc <= w_target;
      // A request still in flight must be drained before the new fetch starts.
      if (w_held || imemValid) r_state <= FETCH;
      else                     r_state <= DRAIN;
    end else begin
      case (r_state)
        FETCH: begin
          if (imemValid) begin
            if (pcWrite) begin
              r_pc <= w_pc_plus4;
            end else begin
              r_hold  <= imemData;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (pcWrite) begin
            r_pc    <= w_pc_plus4;
            r_state <= FETCH;
          end
        end
        DRAIN: begin
          if (imemValid) r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: cycle-by-cycle vector table plus reset corner sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcWrite, branchTaken, jump, imemValid;
  logic [31:0] branchTarget, jumpTarget, imemData;

  logic        req0, wr0, fl0, req1, wr1, fl1;
  logic [31:0] addr0, pcin0, ins0, addr1, pcin1, ins1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .pcWrite(pcWrite),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget),
    .imemReq(req0), .imemAddr(addr0), .imemValid(imemValid), .imemData(imemData),
    .ifidPCin(pcin0), .ifidInstructionIn(ins0), .ifidWrite(wr0), .ifFlush(fl0)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .pcWrite(pcWrite),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget),
    .imemReq(req1), .imemAddr(addr1), .imemValid(imemValid), .imemData(imemData),
    .ifidPCin(pcin1), .ifidInstructionIn(ins1), .ifidWrite(wr1), .ifFlush(fl1)
  );

  typedef struct {
    logic        pw;
    logic        bt;
    logic [31:0] btgt;
    logic        jp;
    logic [31:0] jtgt;
    logic        vld;
    logic [31:0] dat;
    logic        req;
    logic [31:0] addr;
    logic        wr;
    logic        fl;
    logic [31:0] pcin;
    logic [31:0] ins;
  } vec_t;

  vec_t vt[35];

  function automatic vec_t mk(input logic pw, input logic bt, input logic [31:0] btgt,
                              input logic jp, input logic [31:0] jtgt,
                              input logic vld, input logic [31:0] dat,
                              input logic req, input logic [31:0] addr,
                              input logic wr, input logic fl,
                              input logic [31:0] pcin, input logic [31:0] ins);
    vec_t v;
    v.pw = pw; v.bt = bt; v.btgt = btgt; v.jp = jp; v.jtgt = jtgt;
    v.vld = vld; v.dat = dat; v.req = req; v.addr = addr;
    v.wr = wr; v.fl = fl; v.pcin = pcin; v.ins = ins;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic bt, input logic [31:0] btgt,
                       input logic jp, input logic [31:0] jtgt,
                       input logic vld, input logic [31:0] dat);
    pcWrite = pw; branchTaken = bt; branchTarget = btgt;
    jump = jp; jumpTarget = jtgt; imemValid = vld; imemData = dat;
  endtask

  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  initial begin
    // pw bt btgt jp jtgt vld dat | req addr wr fl pcin ins
    vt[0]  = mk(1,0,0,0,0, 0,0,            1,32'h0,  0,1,0,0);
    vt[1]  = mk(1,0,0,0,0, 1,32'hA000_0000, 1,32'h0,  1,0,32'h4,32'hA000_0000);
    vt[2]  = mk(1,0,0,0,0, 0,0,            1,32'h4,  0,1,0,0);
    vt[3]  = mk(1,0,0,0,0, 1,32'hA000_0001, 1,32'h4,  1,0,32'h8,32'hA000_0001);
    vt[4]  = mk(1,0,0,0,0, 0,0,            1,32'h8,  0,1,0,0);
    vt[5]  = mk(1,0,0,0,0, 1,32'hA000_0002, 1,32'h8,  1,0,32'hC,32'hA000_0002);
    vt[6]  = mk(0,0,0,0,0, 0,0,            1,32'hC,  0,0,0,0);
    vt[7]  = mk(0,0,0,0,0, 1,32'hA000_0003, 1,32'hC,  0,0,0,0);
    vt[8]  = mk(0,0,0,0,0, 0,BAD,          0,0,      0,0,0,0);
    vt[9]  = mk(0,0,0,0,0, 0,BAD,          0,0,      0,0,0,0);
    vt[10] = mk(0,0,0,0,0, 0,BAD,          0,0,      0,0,0,0);
    vt[11] = mk(1,0,0,0,0, 0,BAD,          0,0,      1,0,32'h10,32'hA000_0003);
    vt[12] = mk(1,0,0,0,0, 0,0,            1,32'h10, 0,1,0,0);
    vt[13] = mk(1,1,32'h100,0,0, 0,0,      1,32'h10, 0,1,0,0);
    vt[14] = mk(1,0,0,0,0, 0,0,            0,0,      0,1,0,0);
    vt[15] = mk(1,0,0,0,0, 1,BAD,          0,0,      0,1,0,0);
    vt[16] = mk(1,0,0,0,0, 0,0,            1,32'h100,0,1,0,0);
    vt[17] = mk(1,0,0,0,0, 1,32'hA000_0004, 1,32'h100,1,0,32'h104,32'hA000_0004);
    vt[18] = mk(1,1,32'h200,1,32'h300, 0,0, 1,32'h104,0,1,0,0);
    vt[19] = mk(1,0,0,0,0, 1,BAD,          0,0,      0,1,0,0);
    vt[20] = mk(1,0,0,0,0, 0,0,            1,32'h200,0,1,0,0);
    vt[21] = mk(0,0,0,1,32'h403, 1,BAD,    1,32'h200,0,1,0,0);
    vt[22] = mk(0,0,0,0,0, 0,0,            1,32'h400,0,0,0,0);
    vt[23] = mk(0,0,0,0,0, 1,32'hA000_0005, 1,32'h400,0,0,0,0);
    vt[24] = mk(0,1,32'h500,0,0, 0,0,      0,0,      0,1,0,0);
    vt[25] = mk(0,0,0,0,0, 0,0,            1,32'h500,0,0,0,0);
    vt[26] = mk(1,0,0,0,0, 1,32'hA000_0006, 1,32'h500,1,0,32'h504,32'hA000_0006);
    vt[27] = mk(1,0,0,1,32'h600, 0,0,      1,32'h504,0,1,0,0);
    vt[28] = mk(0,0,0,0,0, 0,0,            0,0,      0,0,0,0);
    vt[29] = mk(0,0,0,0,0, 1,BAD,          0,0,      0,0,0,0);
    vt[30] = mk(1,0,0,0,0, 0,0,            1,32'h600,0,1,0,0);
    vt[31] = mk(1,1,32'h700,0,0, 0,0,      1,32'h600,0,1,0,0);
    vt[32] = mk(1,1,32'h802,0,0, 0,0,      0,0,      0,1,0,0);
    vt[33] = mk(1,0,0,0,0, 1,BAD,          0,0,      0,1,0,0);
    vt[34] = mk(1,0,0,0,0, 0,0,            1,32'h800,0,1,0,0);

    // Reset state, with pcWrite high so an ungated flush would show.
    rst = 1'b0;
    drive(1,0,0,0,0, 0,0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, req0}, 32'd0);
    chk("rst_wr",  {31'd0, wr0},  32'd0);
    chk("rst_fl",  {31'd0, fl0},  32'd0);
    chk("rst_addr", addr0, 32'h0);
    chk("rst_addr1", addr1, 32'hFFFF_FFFC);

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 35; i++) begin
      drive(vt[i].pw, vt[i].bt, vt[i].btgt, vt[i].jp, vt[i].jtgt, vt[i].vld, vt[i].dat);
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, req0}, {31'd0, vt[i].req});
      chk($sformatf("v%0d_wr", i),  {31'd0, wr0},  {31'd0, vt[i].wr});
      chk($sformatf("v%0d_fl", i),  {31'd0, fl0},  {31'd0, vt[i].fl});
      chk($sformatf("v%0d_excl", i), {31'd0, wr0 & fl0}, 32'd0);
      if (vt[i].req) chk($sformatf("v%0d_addr", i), addr0, vt[i].addr);
      if (vt[i].wr) begin
        chk($sformatf("v%0d_pcin", i), pcin0, vt[i].pcin);
        chk($sformatf("v%0d_ins", i),  ins0,  vt[i].ins);
      end
      @(negedge clk);
    end

    // PC wrap from 0xFFFF_FFFC on the second instance.
    rst = 1'b0;
    drive(1,0,0,0,0, 0,0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("wrap_req0", {31'd0, req1}, 32'd1);
    chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(1,0,0,0,0, 1,32'hC0DE_0001);
    #1;
    chk("wrap_wr", {31'd0, wr1}, 32'd1);
    chk("wrap_pcin", pcin1, 32'h0);
    chk("wrap_ins", ins1, 32'hC0DE_0001);
    @(negedge clk);
    drive(1,0,0,0,0, 0,0);
    #1;
    chk("wrap_req1", {31'd0, req1}, 32'd1);
    chk("wrap_addr1", addr1, 32'h0);

    // Asynchronous reset while in HOLD, asserted and released between clock edges.
    @(negedge clk);
    drive(0,0,0,0,0, 1,32'hC0DE_0002);
    @(negedge clk);
    drive(0,0,0,0,0, 0,0);
    #1;
    chk("hold_req", {31'd0, req0}, 32'd0);
    #1;
    rst = 1'b0;
    pcWrite = 1'b1;
    #1;
    chk("arst_req", {31'd0, req0}, 32'd0);
    chk("arst_wr",  {31'd0, wr0},  32'd0);
    chk("arst_fl",  {31'd0, fl0},  32'd0);
    #1;
    rst = 1'b1;
    #0.5;
    chk("arst_rel_req", {31'd0, req0}, 32'd1);
    chk("arst_rel_addr", addr0, 32'h0);
    chk("arst_rel_addr1", addr1, 32'hFFFF_FFFC);
    chk("arst_rel_fl", {31'd0, fl0}, 32'd1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
